mem_tester: RTL

Parametrised, synthesisable self-checking traffic generator for the memory subsystem's single-port request/ready interface (ram, spm, cache, split/combine trees). It sits in the master position in place of a hand-written stimulus process. It writes a programmable pattern over an address window, reads it back, compares the data, and reports pass/fail, error count, first failing address, latency statistics and timeout.

---
 rtl/mem_tester.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_tester.sv
`default_nettype none
// ============================================================================
//  Module   : mem_tester
//  Purpose  : Self-checking traffic generator for a single-port request/ready
//             memory interface. Writes pat(i) = SEED + i*STEP to
//             addr(i) = BASE + i*STRIDE for i in 0..COUNT-1, reads every word
//             back, compares, and reports pass/fail, error count, first
//             failing address, busy-cycle count, worst latency and timeout.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             start                 - begin a run (honoured in IDLE/DONE)
//             busy, done, pass      - run status
//             timeout               - an access waited TIMEOUT cycles
//             error_count           - read mismatches (saturating)
//             first_error_addr      - address of the first mismatch
//             cycle_count           - cycles spent busy (saturating)
//             max_latency           - longest WAIT duration in cycles
//             mem_addr/mem_din      - request address / write data
//             mem_dout              - read data from memory
//             mem_re/mem_we         - read / write strobes (REQ only)
//             mem_ready             - memory idle / access complete
//  Revision : 1.0  initial release
// ============================================================================
module mem_tester #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          COUNT      = 256,
  parameter logic [63:0] BASE       = 64'd0,
  parameter logic [63:0] STRIDE     = 64'd1,
  parameter logic [63:0] SEED       = 64'h0123456789abcdef,
  parameter logic [63:0] STEP       = 64'd1,
  parameter int          MODE       = 0,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_error_addr,
  output logic [31:0]           cycle_count,
  output logic [31:0]           max_latency,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic                  mem_ready
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_HOLD = 3'd1;
  localparam logic [2:0] c_REQ  = 3'd2;
  localparam logic [2:0] c_WAIT = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] c_BASE    = ADDR_WIDTH'(BASE);
  localparam logic [ADDR_WIDTH-1:0] c_STRIDE  = ADDR_WIDTH'(STRIDE);
  localparam logic [DATA_WIDTH-1:0] c_SEED    = DATA_WIDTH'(SEED);
  localparam logic [DATA_WIDTH-1:0] c_STEP    = DATA_WIDTH'(STEP);
  localparam logic [31:0]           c_LAST    = (COUNT == 0) ? 32'd0 : 32'(COUNT - 1);
  localparam logic [31:0]           c_TIMEOUT = 32'(TIMEOUT);

  logic [2:0]            r_state;
  logic                  r_is_read;   // current operation is a read
  logic [31:0]           r_idx;       // word index of current operation
  logic [DATA_WIDTH-1:0] r_cur_pat;   // pat(r_idx), also the read reference
  logic [ADDR_WIDTH-1:0] r_mem_addr;  // doubles as the address cursor
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic [31:0]           r_wait_cnt;  // WAIT cycles already elapsed
  logic                  r_timeout;
  logic [15:0]           r_error_count;
  logic [ADDR_WIDTH-1:0] r_first_error_addr;
  logic [31:0]           r_cycle_count;
  logic [31:0]           r_max_latency;

  logic [31:0]           w_lat;
  logic [31:0]           w_max_upd;
  logic                  w_last_op;
  logic                  w_nxt_read;
  logic [31:0]           w_nxt_idx;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic [DATA_WIDTH-1:0] w_nxt_pat;

  // Latency of the access if it finishes (or times out) this cycle.
  assign w_lat     = r_wait_cnt + 32'd1;
  assign w_max_upd = (w_lat > r_max_latency) ? w_lat : r_max_latency;
  // Both modes end on the read of the last word.
  assign w_last_op = r_is_read && (r_idx == c_LAST);

  // Cursor for the operation following the current one.
  always_comb begin
    w_nxt_read = r_is_read;
    w_nxt_idx  = r_idx;
    w_nxt_addr = r_mem_addr;
    w_nxt_pat  = r_cur_pat;
    if (MODE != 0) begin
      if (!r_is_read) begin
        // Interleaved: read back the word just written.
        w_nxt_read = 1'b1;
      end else begin
        w_nxt_read = 1'b0;
        w_nxt_idx  = r_idx + 32'd1;
        w_nxt_addr = r_mem_addr + c_STRIDE;
        w_nxt_pat  = r_cur_pat + c_STEP;
      end
    end else begin
      if (r_idx == c_LAST) begin
        // End of the write pass: rewind the cursor for the read pass.
        w_nxt_read = 1'b1;
        w_nxt_idx  = 32'd0;
        w_nxt_addr = c_BASE;
        w_nxt_pat  = c_SEED;
      end else begin
        w_nxt_idx  = r_idx + 32'd1;
        w_nxt_addr = r_mem_addr + c_STRIDE;
        w_nxt_pat  = r_cur_pat + c_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= c_IDLE;
      r_is_read          <= 1'b0;
      r_idx              <= 32'd0;
      r_cur_pat          <= '0;
      r_mem_addr         <= '0;
      r_mem_din          <= '0;
      r_wait_cnt         <= 32'd0;
      r_timeout          <= 1'b0;
      r_error_count      <= 16'd0;
      r_first_error_addr <= '0;
      r_cycle_count      <= 32'd0;
      r_max_latency      <= 32'd0;
    end else begin
      if ((r_state == c_HOLD) || (r_state == c_REQ) || (r_state == c_WAIT)) begin
        if (r_cycle_count != 32'hffff_ffff) begin
          r_cycle_count <= r_cycle_count + 32'd1;
        end
      end

      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_is_read          <= 1'b0;
            r_idx              <= 32'd0;
            r_cur_pat          <= c_SEED;
            r_mem_addr         <= c_BASE;
            r_mem_din          <= c_SEED;
            r_wait_cnt         <= 32'd0;
            r_timeout          <= 1'b0;
            r_error_count      <= 16'd0;
            r_first_error_addr <= '0;
            r_cycle_count      <= 32'd0;
            r_max_latency      <= 32'd0;
            r_state            <= (COUNT == 0) ? c_DONE : c_HOLD;
          end
        end

        c_HOLD: begin
          if (mem_ready) begin
            r_state <= c_REQ;
          end
        end

        c_REQ: begin
          r_wait_cnt <= 32'd0;
          r_state    <= c_WAIT;
        end

        c_WAIT: begin
          if (mem_ready) begin
            r_max_latency <= w_max_upd;
            if (r_is_read && (mem_dout != r_cur_pat)) begin
              if (r_error_count != 16'hffff) begin
                r_error_count <= r_error_count + 16'd1;
              end
              if (r_error_count == 16'd0) begin
                r_first_error_addr <= r_mem_addr;
              end
            end
            if (w_last_op) begin
              r_state <= c_DONE;
            end else begin
              r_is_read  <= w_nxt_read;
              r_idx      <= w_nxt_idx;
              r_mem_addr <= w_nxt_addr;
              r_cur_pat  <= w_nxt_pat;
              r_mem_din  <= w_nxt_read ? '0 : w_nxt_pat;
              r_state    <= c_REQ;
            end
          end else if (w_lat >= c_TIMEOUT) begin
            r_max_latency <= w_max_upd;
            r_timeout     <= 1'b1;
            r_state       <= c_DONE;
          end else begin
            r_wait_cnt <= w_lat;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy             = (r_state == c_HOLD) || (r_state == c_REQ) || (r_state == c_WAIT);
  assign done             = (r_state == c_DONE);
  assign pass             = (r_state == c_DONE) && (r_error_count == 16'd0) && !r_timeout;
  assign timeout          = r_timeout;
  assign error_count      = r_error_count;
  assign first_error_addr = r_first_error_addr;
  assign cycle_count      = r_cycle_count;
  assign max_latency      = r_max_latency;
  assign mem_addr         = r_mem_addr;
  assign mem_din          = r_mem_din;
  // Strobes come straight from the state register: one cycle, never both.
  assign mem_re           = (r_state == c_REQ) && r_is_read;
  assign mem_we           = (r_state == c_REQ) && !r_is_read;

endmodule
`default_nettype wire
